// File: rtl/sprite_queue.sv
// sprite_queue: committed-frame FIFO of sprite draw descriptors (id, x, y, scale).
// Entries written during a frame stay hidden from the consumer until frame_commit;
// frame_abort throws the uncommitted part away. The head is first-word-fall-through.
// Optional macro SPRITE_QUEUE_STATS_EN adds drop_count and high_water outputs.
module sprite_queue #(
    parameter int DEPTH = 64,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    input  logic [7:0]       enq_id,
    input  logic [15:0]      enq_x,
    input  logic [15:0]      enq_y,
    input  logic [7:0]       enq_scale,
    output logic             enq_ready,
    input  logic             frame_commit,
    input  logic             frame_abort,
    input  logic             dequeue,
    output logic             is_empty,
    output logic [7:0]       sprite_id,
    output logic [15:0]      sprite_x,
    output logic [15:0]      sprite_y,
    output logic [7:0]       sprite_scale,
    output logic [PTR_W:0]   committed_count,
    output logic             overflow
`ifdef SPRITE_QUEUE_STATS_EN
    ,
    output logic [15:0]      drop_count,
    output logic [PTR_W:0]   high_water
`endif
);

    localparam logic [PTR_W:0] DEPTH_PTR = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE   = (PTR_W + 1)'(1);

    // Descriptor storage, packed as {id, x, y, scale}; contents are don't-care after reset
    logic [47:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] commit_ptr;
    logic [PTR_W:0] rd_ptr;

    logic [PTR_W:0] wr_ptr_nxt;
    logic [PTR_W:0] commit_ptr_nxt;
    logic [PTR_W:0] rd_ptr_nxt;

    logic           full;
    logic           do_enq;
    logic           do_deq;
    logic           drop;
    logic [47:0]    head;

    // Occupancy flags and the accept/drop decisions, all based on pre-edge state
    always_comb begin
        full      = (wr_ptr - rd_ptr) == DEPTH_PTR;
        is_empty  = (rd_ptr == commit_ptr);
        enq_ready = !full;
        committed_count = commit_ptr - rd_ptr;
        do_enq    = enq_valid && !full;
        do_deq    = dequeue && !is_empty;
        // An abort that is not overridden by a commit discards the write anyway,
        // so a full-queue enqueue in that cycle is not counted as a drop.
        drop      = enq_valid && full && !(frame_abort && !frame_commit);
    end

    // Pointer next-state: commit publishes up to and including this cycle's write,
    // abort rewinds the write pointer, and commit takes priority over abort
    always_comb begin
        wr_ptr_nxt     = wr_ptr + (do_enq ? PTR_ONE : '0);
        commit_ptr_nxt = commit_ptr;
        rd_ptr_nxt     = rd_ptr + (do_deq ? PTR_ONE : '0);
        if (frame_commit) begin
            commit_ptr_nxt = wr_ptr_nxt;
        end else if (frame_abort) begin
            wr_ptr_nxt = commit_ptr;
        end
    end

    // First-word-fall-through head, forced to zero when nothing is committed
    always_comb begin
        head = mem[rd_ptr[PTR_W-1:0]];
        if (is_empty) begin
            head = '0;
        end
        sprite_id    = head[47:40];
        sprite_x     = head[39:24];
        sprite_y     = head[23:8];
        sprite_scale = head[7:0];
    end

    // Descriptor write port; no reset so the array can map onto RAM
    always_ff @(posedge clock) begin
        if (do_enq) begin
            mem[wr_ptr[PTR_W-1:0]] <= {enq_id, enq_x, enq_y, enq_scale};
        end
    end

    // Pointer and sticky overflow registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef SPRITE_QUEUE_STATS_EN
    logic [PTR_W:0] occupancy_nxt;

    // Occupancy after this edge, used for the high-water mark
    always_comb begin
        occupancy_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    // Saturating drop counter and running maximum of total occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count <= '0;
            high_water <= '0;
        end else begin
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            if (occupancy_nxt > high_water) begin
                high_water <= occupancy_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sprite_queue.sv
// tb_sprite_queue: directed plus randomized checks of sprite_queue (DEPTH=4)
// against a queue-based model of committed and pending descriptors.
module tb_sprite_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clock;
    logic             reset;
    logic             enq_valid;
    logic [7:0]       enq_id;
    logic [15:0]      enq_x;
    logic [15:0]      enq_y;
    logic [7:0]       enq_scale;
    logic             enq_ready;
    logic             frame_commit;
    logic             frame_abort;
    logic             dequeue;
    logic             is_empty;
    logic [7:0]       sprite_id;
    logic [15:0]      sprite_x;
    logic [15:0]      sprite_y;
    logic [7:0]       sprite_scale;
    logic [PTR_W:0]   committed_count;
    logic             overflow;
`ifdef SPRITE_QUEUE_STATS_EN
    logic [15:0]      drop_count;
    logic [PTR_W:0]   high_water;
`endif

    int error_count = 0;
    int check_count = 0;

    // Reference model: committed entries visible to the consumer, pending ones not yet
    logic [47:0] committed_q[$];
    logic [47:0] pending_q[$];
    logic        model_overflow;
    int          model_drops;
    int          model_high_water;

    sprite_queue #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .enq_valid       (enq_valid),
        .enq_id          (enq_id),
        .enq_x           (enq_x),
        .enq_y           (enq_y),
        .enq_scale       (enq_scale),
        .enq_ready       (enq_ready),
        .frame_commit    (frame_commit),
        .frame_abort     (frame_abort),
        .dequeue         (dequeue),
        .is_empty        (is_empty),
        .sprite_id       (sprite_id),
        .sprite_x        (sprite_x),
        .sprite_y        (sprite_y),
        .sprite_scale    (sprite_scale),
        .committed_count (committed_count),
        .overflow        (overflow)
`ifdef SPRITE_QUEUE_STATS_EN
        ,
        .drop_count      (drop_count),
        .high_water      (high_water)
`endif
    );

    // Free-running pixel clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [47:0] actual, input logic [47:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        committed_q.delete();
        pending_q.delete();
        model_overflow   = 1'b0;
        model_drops      = 0;
        model_high_water = 0;
    endtask

    task automatic model_step(input logic enq, input logic [47:0] data, input logic commit,
                              input logic abort, input logic deq);
        int  occ;
        bit  was_full;
        occ      = committed_q.size() + pending_q.size();
        was_full = (occ == DEPTH);
        if (deq && committed_q.size() > 0) void'(committed_q.pop_front());
        if (enq && !was_full) pending_q.push_back(data);
        if (commit) begin
            foreach (pending_q[i]) committed_q.push_back(pending_q[i]);
            pending_q.delete();
        end else if (abort) begin
            pending_q.delete();
        end
        if (enq && was_full && !(abort && !commit)) begin
            model_overflow = 1'b1;
            if (model_drops < 65535) model_drops++;
        end
        occ = committed_q.size() + pending_q.size();
        if (occ > model_high_water) model_high_water = occ;
    endtask

    task automatic checkState();
        logic [47:0]    exp_head;
        logic [PTR_W:0] dist_rw;
        logic [PTR_W:0] dist_rc;
        int             occ;
        occ      = committed_q.size() + pending_q.size();
        exp_head = (committed_q.size() > 0) ? committed_q[0] : 48'd0;
        checkOutput("is_empty", 48'(is_empty), 48'(committed_q.size() == 0));
        checkOutput("enq_ready", 48'(enq_ready), 48'(occ != DEPTH));
        checkOutput("committed_count", 48'(committed_count), 48'(committed_q.size()));
        checkOutput("head", {sprite_id, sprite_x, sprite_y, sprite_scale}, exp_head);
        checkOutput("overflow", 48'(overflow), 48'(model_overflow));
        dist_rw = dut.wr_ptr - dut.rd_ptr;
        dist_rc = dut.commit_ptr - dut.rd_ptr;
        checkOutput("ptr_invariant", 48'((dist_rc <= dist_rw) && (int'(dist_rw) <= DEPTH)), 48'd1);
`ifdef SPRITE_QUEUE_STATS_EN
        checkOutput("drop_count", 48'(drop_count), 48'(model_drops));
        checkOutput("high_water", 48'(high_water), 48'(model_high_water));
`endif
    endtask

    // One clock of stimulus: drive, advance model at the edge, check at the falling edge
    task automatic applyStimulus(input logic enq, input logic [7:0] id, input logic [15:0] x,
                                 input logic [15:0] y, input logic [7:0] scale,
                                 input logic commit, input logic abort, input logic deq);
        enq_valid    = enq;
        enq_id       = id;
        enq_x        = x;
        enq_y        = y;
        enq_scale    = scale;
        frame_commit = commit;
        frame_abort  = abort;
        dequeue      = deq;
        @(posedge clock);
        model_step(enq, {id, x, y, scale}, commit, abort, deq);
        @(negedge clock);
        checkState();
    endtask

    task automatic applyReset();
        reset        = 1'b1;
        enq_valid    = 1'b0;
        enq_id       = '0;
        enq_x        = '0;
        enq_y        = '0;
        enq_scale    = '0;
        frame_commit = 1'b0;
        frame_abort  = 1'b0;
        dequeue      = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        checkState();
    endtask

    // Shorthands for id-only descriptors
    task automatic enq_only(input logic [7:0] id);
        applyStimulus(1'b1, id, 16'(id) * 16'd10, 16'(id) + 16'd7, id ^ 8'h5A, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic deq_only();
        applyStimulus(1'b0, 8'd0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic commit_only();
        applyStimulus(1'b0, 8'd0, 16'd0, 16'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        applyReset();
        checkOutput("reset_is_empty", 48'(is_empty), 48'd1);
        checkOutput("reset_sprite_id", 48'(sprite_id), 48'd0);

        // Commit gating
        applyStimulus(1'b1, 8'd3, 16'd100, 16'd50, 8'd8, 1'b0, 1'b0, 1'b0);
        checkOutput("gate_hidden", 48'(is_empty), 48'd1);
        commit_only();
        checkOutput("gate_visible", 48'(is_empty), 48'd0);
        checkOutput("gate_head", {sprite_id, sprite_x, sprite_y, sprite_scale},
                    {8'd3, 16'd100, 16'd50, 8'd8});
        deq_only();
        checkOutput("gate_drained", 48'(is_empty), 48'd1);

        // Fill to full, drop the fifth, then drain in order
        for (int i = 1; i <= 5; i++) enq_only(8'(i));
        checkOutput("full_ready", 48'(enq_ready), 48'd0);
        checkOutput("full_overflow", 48'(overflow), 48'd1);
        commit_only();
        checkOutput("full_count", 48'(committed_count), 48'd4);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain_order", 48'(sprite_id), 48'(i));
            deq_only();
        end
        checkOutput("drain_count", 48'(committed_count), 48'd0);

        // Abort discards only the uncommitted tail
        enq_only(8'd1);
        applyStimulus(1'b1, 8'd2, 16'd20, 16'd9, 8'd1, 1'b1, 1'b0, 1'b0);
        enq_only(8'd7);
        enq_only(8'd8);
        applyStimulus(1'b0, 8'd0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("abort_count", 48'(committed_count), 48'd2);
        deq_only();
        deq_only();
        applyStimulus(1'b1, 8'd9, 16'd90, 16'd16, 8'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("abort_next", 48'(sprite_id), 48'd9);
        deq_only();

        // Commit beats abort; same-cycle enqueue is included
        applyStimulus(1'b1, 8'd6, 16'd60, 16'd13, 8'd2, 1'b1, 1'b1, 1'b0);
        checkOutput("simul_count", 48'(committed_count), 48'd1);
        checkOutput("simul_id", 48'(sprite_id), 48'd6);
        deq_only();
        deq_only();
        checkOutput("empty_deq", 48'(dut.rd_ptr), 48'(dut.commit_ptr));

        // Wrap: ten 3-entry frames from a clean reset
        applyReset();
        for (int f = 0; f < 10; f++) begin
            for (int e = 0; e < 3; e++) begin
                applyStimulus(1'b1, 8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
                              e == 2, 1'b0, 1'b0);
            end
            for (int e = 0; e < 3; e++) deq_only();
            checkOutput("wrap_empty", 48'(is_empty), 48'd1);
        end
`ifdef SPRITE_QUEUE_STATS_EN
        checkOutput("wrap_high_water", 48'(high_water), 48'd3);
        checkOutput("wrap_drop_count", 48'(drop_count), 48'd0);
`endif

        // Random traffic, including simultaneous commit/abort/dequeue
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 9) < 6, 8'($urandom), 16'($urandom), 16'($urandom),
                          8'($urandom), $urandom_range(0, 9) < 1, $urandom_range(0, 19) < 1,
                          $urandom_range(0, 9) < 4);
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/sprite_queue.md
Name: sprite_queue

Overview:
- Committed-frame FIFO between the SPI command decoder (producer) and sprite_driver (consumer) carrying draw descriptors: id, x, y, scale.
- Entries written during an SPI frame stay invisible to the consumer until the producer pulses frame_commit. sprite_driver therefore never draws a partially transmitted sprite list.
- Runs in the pixel_clk domain; the producer side is already synchronised to that clock.

Parameters:
- DEPTH, 64, number of descriptor entries; power of 2, minimum 4.
- PTR_W, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
- clock  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enq_valid  in  1  producer writes one descriptor this cycle.
- enq_id  in  8  sprite id.
- enq_x  in  16  sprite x.
- enq_y  in  16  sprite y.
- enq_scale  in  8  sprite scale.
- enq_ready  out  1  high when not full.
- frame_commit  in  1  pulse: publish all written entries.
- frame_abort  in  1  pulse: discard uncommitted entries.
- dequeue  in  1  consumer pops head entry.
- is_empty  out  1  no committed entry available.
- sprite_id  out  8  head id.
- sprite_x  out  16  head x.
- sprite_y  out  16  head y.
- sprite_scale  out  8  head scale.
- committed_count  out  PTR_W+1  committed, not-yet-dequeued entries.
- overflow  out  1  sticky: an enqueue was dropped.

Behaviour:
- Storage: DEPTH x 48-bit array, not reset.
- Pointers: wr_ptr, commit_ptr, rd_ptr, each PTR_W+1 bits, wrap modulo 2*DEPTH. Index = low PTR_W bits.
- Reset: all pointers 0, overflow 0. Outputs: is_empty 1, enq_ready 1, committed_count 0, sprite_* 0.
- full = (wr_ptr - rd_ptr) == DEPTH. enq_ready = !full.
- is_empty = (rd_ptr == commit_ptr).
- committed_count = commit_ptr - rd_ptr.
- Head output is first-word-fall-through:
  - sprite_* read combinationally from storage at rd_ptr when !is_empty.
  - sprite_* forced to 0 when is_empty.
  - Zero-cycle latency from commit register update to head visible.
- Enqueue: when enq_valid && !full, write at wr_ptr and increment wr_ptr.
- Enqueue when full: write dropped, wr_ptr unchanged, overflow <= 1.
  - full is evaluated on the pre-edge state, so a same-cycle dequeue does not admit the write.
- Dequeue: when dequeue && !is_empty, increment rd_ptr. Dequeue while empty is ignored, no error.
- frame_commit: commit_ptr <= next wr_ptr. An enqueue in the same cycle is included in the commit.
- frame_abort: wr_ptr <= commit_ptr. An enqueue in the same cycle is discarded; overflow is not set for it.
- Commit and abort in the same cycle: commit wins, abort ignored.
- Dequeue and commit in the same cycle: both take effect. is_empty next cycle reflects the new commit_ptr and rd_ptr.
- overflow is cleared only by reset.
- Reset mid-frame: uncommitted and committed entries are both lost. No partial state survives.
- Invariants: rd_ptr <= commit_ptr <= wr_ptr, modulo arithmetic, distance <= DEPTH. The bench asserts these every cycle.

Optional Feature:
- Macro: SPRITE_QUEUE_STATS_EN.
- Defined: adds outputs drop_count (16 bit, saturating at 0xFFFF) and high_water (PTR_W+1 bit, maximum of wr_ptr - rd_ptr since reset).
  - drop_count increments once per dropped enqueue.
  - Both reset to 0.
- Undefined: ports absent. No counter logic; overflow flag unchanged.

Test Plan (DEPTH=4):
- Reset: after reset -> is_empty=1, enq_ready=1, committed_count=0, sprite_*=0, overflow=0.
- Commit gating:
  - Enqueue (id=3, x=100, y=50, scale=8), no commit -> is_empty stays 1.
  - Pulse frame_commit -> next cycle is_empty=0, sprite_id=3, sprite_x=100, sprite_y=50, sprite_scale=8.
  - dequeue -> is_empty=1.
- Full/overflow:
  - Enqueue ids 1..5 back-to-back -> enq_ready=0 after 4th; 5th dropped; overflow=1.
  - Commit, drain -> ids 1,2,3,4 in order, committed_count 4->0.
- Abort:
  - Commit ids 1,2; enqueue 7,8; frame_abort -> only 1,2 dequeue.
  - Next enqueue 9 + commit -> 9 follows 2.
- Simultaneous:
  - Enqueue id=6 with frame_commit and frame_abort in the same cycle -> id 6 committed, committed_count +1.
  - Dequeue on empty -> no pointer change.
- Wrap: 10 frames of 3 entries each, committed and drained -> pointers wrap past 2*DEPTH with correct order and no spurious empty/full. With SPRITE_QUEUE_STATS_EN defined: high_water=3, drop_count=0.
